// File: rtl/db_multi.sv
// Multi-channel switch debouncer: per-channel synchroniser chain feeding a
// four-state stability FSM with registered level, rise and fall outputs.
module db_multi #(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sw,
    output logic [N-1:0] db,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_r;
            logic                   s_s;
            state_t                 state_r;
            state_t                 state_s;
            logic [CW-1:0]          cnt_r;
            logic [CW-1:0]          cnt_s;
            logic                   db_r;
            logic                   rise_r;
            logic                   fall_r;
            logic                   db_s;
            logic                   rise_s;
            logic                   fall_s;

            // Synchroniser chain shifting the raw input toward the last stage
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_r <= {SYNC_STAGES{1'b0}};
                end else begin
                    sync_r <= {sync_r[SYNC_STAGES-2:0], sw[g]};
                end
            end

            assign s_s = sync_r[SYNC_STAGES-1];

            // Next-state, counter and pulse decode for the stability FSM
            always_comb begin
                state_s = state_r;
                cnt_s   = cnt_r;
                rise_s  = 1'b0;
                fall_s  = 1'b0;
                case (state_r)
                    ZERO: begin
                        if (s_s) begin
                            state_s = WAIT1;
                            cnt_s   = CNT_ONE;
                        end else begin
                            cnt_s   = CNT_ZERO;
                        end
                    end
                    WAIT1: begin
                        if (!s_s) begin
                            state_s = ZERO;
                            cnt_s   = CNT_ZERO;
                        end else if (cnt_r == CNT_MAX) begin
                            state_s = ONE;
                            cnt_s   = CNT_ZERO;
                            rise_s  = 1'b1;
                        end else begin
                            cnt_s   = cnt_r + CNT_ONE;
                        end
                    end
                    ONE: begin
                        if (!s_s) begin
                            state_s = WAIT0;
                            cnt_s   = CNT_ONE;
                        end else begin
                            cnt_s   = CNT_ZERO;
                        end
                    end
                    WAIT0: begin
                        if (s_s) begin
                            state_s = ONE;
                            cnt_s   = CNT_ZERO;
                        end else if (cnt_r == CNT_MAX) begin
                            state_s = ZERO;
                            cnt_s   = CNT_ZERO;
                            fall_s  = 1'b1;
                        end else begin
                            cnt_s   = cnt_r + CNT_ONE;
                        end
                    end
                    default: begin
                        state_s = ZERO;
                        cnt_s   = CNT_ZERO;
                    end
                endcase
                // The level follows the state being entered so db and the pulse share an edge
                db_s = (state_s == ONE) || (state_s == WAIT0);
            end

            // FSM state, counter and registered outputs
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_r <= ZERO;
                    cnt_r   <= CNT_ZERO;
                    db_r    <= 1'b0;
                    rise_r  <= 1'b0;
                    fall_r  <= 1'b0;
                end else begin
                    state_r <= state_s;
                    cnt_r   <= cnt_s;
                    db_r    <= db_s;
                    rise_r  <= rise_s;
                    fall_r  <= fall_s;
                end
            end

            assign db[g]   = db_r;
            assign rise[g] = rise_r;
            assign fall[g] = fall_r;
        end
    endgenerate

endmodule

// File: tb/tb_db_multi.sv
// Scoreboard bench for db_multi: stimulus queues expected pulse events,
// a negedge monitor pops and compares whenever rise or fall is asserted.
`timescale 1ns/1ps
module tb_db_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw;
    logic [3:0] db;
    logic [3:0] rise;
    logic [3:0] fall;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         at;
        logic [3:0] r;
        logic [3:0] f;
        logic [3:0] d;
    } ev_t;

    ev_t exp_q[$];

    db_multi #(.N(4), .STABLE_CYCLES(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .db    (db),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // An event is expected 10 counted edges after the negedge on which sw changed
    task automatic expect_ev(input logic [3:0] r, input logic [3:0] f, input logic [3:0] d);
        ev_t e;
        e.at = cyc + 10;
        e.r  = r;
        e.f  = f;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rise !== 4'h0 || fall !== 4'h0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: rise=%0h fall=%0h db=%0h at cycle %0d", rise, fall, db, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("event_cycle", cyc, e.at);
                chk("event_rise", {28'd0, rise}, {28'd0, e.r});
                chk("event_fall", {28'd0, fall}, {28'd0, e.f});
                chk("event_db", {28'd0, db}, {28'd0, e.d});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int bounce[9] = '{7, 3, 4, 2, 2, 2, 3, 5, 0};

    initial begin
        reset = 1'b1;
        sw    = 4'hF;
        idle(3);
        chk("reset_db", {28'd0, db}, 32'd0);
        chk("reset_rise", {28'd0, rise}, 32'd0);
        chk("reset_fall", {28'd0, fall}, 32'd0);

        // Power-up with all switches held high across release
        reset = 1'b0;
        expect_ev(4'hF, 4'h0, 4'hF);
        idle(9);
        chk("powerup_db_before", {28'd0, db}, 32'd0);
        idle(1);
        chk("powerup_db_after", {28'd0, db}, 32'hF);
        idle(3);
        sw = 4'h0;
        expect_ev(4'h0, 4'hF, 4'h0);
        idle(14);

        // Bounce rejection on channel 0
        for (int i = 0; i < 8; i++) begin
            sw[0] = (i % 2 == 0) ? 1'b1 : 1'b0;
            idle(bounce[i]);
        end
        chk("bounce_db_quiet", {28'd0, db}, 32'd0);
        sw[0] = 1'b1;
        expect_ev(4'h1, 4'h0, 4'h1);
        idle(14);
        sw[0] = 1'b0;
        expect_ev(4'h0, 4'h1, 4'h0);
        idle(14);

        // Threshold boundary on channel 1
        sw[1] = 1'b1;
        idle(7);
        sw[1] = 1'b0;
        idle(14);
        chk("thresh7_db", {28'd0, db}, 32'd0);
        sw[1] = 1'b1;
        expect_ev(4'h2, 4'h0, 4'h2);
        idle(8);
        sw[1] = 1'b0;
        expect_ev(4'h0, 4'h2, 4'h0);
        idle(14);

        // Channel independence: ch2 steps, ch3 chatters
        sw[2] = 1'b1;
        expect_ev(4'h4, 4'h0, 4'h4);
        for (int i = 0; i < 12; i++) begin
            sw[3] = ~sw[3];
            idle(2);
        end
        chk("indep_db", {28'd0, db}, 32'h4);
        sw[3] = 1'b0;
        sw[2] = 1'b0;
        expect_ev(4'h0, 4'h4, 4'h0);
        idle(14);

        // Simultaneous step on all channels
        sw = 4'hF;
        expect_ev(4'hF, 4'h0, 4'hF);
        idle(14);
        sw = 4'h0;
        expect_ev(4'h0, 4'hF, 4'h0);
        idle(14);

        // Reset in the middle of a count
        sw[0] = 1'b1;
        idle(5);
        reset = 1'b1;
        #1;
        chk("midreset_db", {28'd0, db}, 32'd0);
        chk("midreset_rise", {28'd0, rise}, 32'd0);
        idle(2);
        reset = 1'b0;
        expect_ev(4'h1, 4'h0, 4'h1);
        idle(9);
        chk("midreset_db_before", {28'd0, db}, 32'd0);
        idle(1);
        chk("midreset_db_after", {28'd0, db}, 32'h1);
        idle(5);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
